// File: rtl/disp_sched_pkg.sv
// Shared definitions for the display scheduler.
//   state_t   : owner of the seven-segment display (BG timer, CNT mine counter, MSG status)
//   SRC_*     : encoding presented on the src output
//   DP_*      : decimal-point pattern shown for each owner
package disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_BG  = 2'b00,
        ST_CNT = 2'b01,
        ST_MSG = 2'b10
    } state_t;

    localparam logic [1:0] SRC_BG  = 2'b00;
    localparam logic [1:0] SRC_CNT = 2'b01;
    localparam logic [1:0] SRC_MSG = 2'b10;

    localparam logic [3:0] DP_BG  = 4'b0000;
    localparam logic [3:0] DP_CNT = 4'b0001;
    localparam logic [3:0] DP_MSG = 4'b1000;

    function automatic logic [1:0] src_of(input state_t s);
        case (s)
            ST_CNT:  return SRC_CNT;
            ST_MSG:  return SRC_MSG;
            default: return SRC_BG;
        endcase
    endfunction

    function automatic logic [3:0] dp_of(input state_t s);
        case (s)
            ST_CNT:  return DP_CNT;
            ST_MSG:  return DP_MSG;
            default: return DP_BG;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing the hold tick.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : restart the count from 0 (hold entry / restart)
//   tick       : high while the count sits at TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/disp_sched.sv
// Arbitrates the 4-digit display between the game timer (background),
// the mine counter (shown for a hold period on each update) and one-shot
// status messages (request/ack handshake, highest priority).
//   clk, reset          : system clock, synchronous active-high reset
//   bg_val              : live timer digits shown when idle
//   cnt_val, cnt_upd    : mine-counter value and its one-cycle update strobe
//   msg_val, msg_req    : message digits and held request
//   msg_ack, msg_busy   : one-cycle accept pulse, message-owns-display flag
//   hex3..hex0, dp_out  : registered digits / decimal points to disp_hex_mux
//   src                 : registered current owner code
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int TICK_DIV   = 5_000_000,
    parameter int HOLD_TICKS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bg_val,
    input  logic [15:0] cnt_val,
    input  logic        cnt_upd,
    input  logic [15:0] msg_val,
    input  logic        msg_req,
    output logic        msg_ack,
    output logic        msg_busy,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out,
    output logic [1:0]  src
);

    localparam int            HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t        state_q, state_d;
    logic [15:0]   msg_lat_q, msg_lat_d;
    logic [15:0]   cnt_lat_q, cnt_lat_d;
    logic          pend_q, pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ack_q, ack_d;
    logic          busy_q;
    logic [1:0]    src_q;
    logic [15:0]   hex_q, disp_d;
    logic [3:0]    dp_q;
    logic          restart;
    logic          tick;
    logic          expiry;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .tick  (tick)
    );

    // The hold counter free-runs in BG; it only matters after a restart.
    assign expiry = tick && (hold_q == HOLD_LAST) && (state_q != ST_BG);

    always_comb begin
        state_d   = state_q;
        msg_lat_d = msg_lat_q;
        cnt_lat_d = cnt_lat_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_BG, ST_CNT: begin
                if (msg_req) begin
                    // A message pre-empts the counter; a coincident update
                    // is parked so it is shown once the message expires.
                    state_d   = ST_MSG;
                    msg_lat_d = msg_val;
                    ack_d     = 1'b1;
                    restart   = 1'b1;
                    if (cnt_upd) begin
                        cnt_lat_d = cnt_val;
                        pend_d    = 1'b1;
                    end
                end else if (cnt_upd) begin
                    // Update beats a same-cycle expiry: hold restarts.
                    state_d   = ST_CNT;
                    cnt_lat_d = cnt_val;
                    restart   = 1'b1;
                end else if ((state_q == ST_CNT) && expiry) begin
                    state_d = ST_BG;
                end
            end
            ST_MSG: begin
                if (cnt_upd) begin
                    pend_d    = 1'b1;
                    cnt_lat_d = cnt_val;
                end
                if (expiry) begin
                    if (pend_q || cnt_upd) begin
                        state_d = ST_CNT;
                        pend_d  = 1'b0;
                        restart = 1'b1;
                    end else begin
                        state_d = ST_BG;
                    end
                end
            end
            default: state_d = ST_BG;
        endcase

        hold_d = hold_q;
        if (restart) begin
            hold_d = '0;
        end else if (tick) begin
            hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + HW'(1);
        end

        // Digits follow the registered owner, so they trail src by one edge.
        case (state_q)
            ST_CNT:  disp_d = cnt_lat_q;
            ST_MSG:  disp_d = msg_lat_q;
            default: disp_d = bg_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_BG;
            msg_lat_q <= '0;
            cnt_lat_q <= '0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            src_q     <= SRC_BG;
            hex_q     <= '0;
            dp_q      <= DP_BG;
        end else begin
            state_q   <= state_d;
            msg_lat_q <= msg_lat_d;
            cnt_lat_q <= cnt_lat_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
            ack_q     <= ack_d;
            busy_q    <= (state_d == ST_MSG);
            src_q     <= src_of(state_d);
            hex_q     <= disp_d;
            dp_q      <= dp_of(state_q);
        end
    end

    assign msg_ack  = ack_q;
    assign msg_busy = busy_q;
    assign src      = src_q;
    assign dp_out   = dp_q;
    assign hex3     = hex_q[15:12];
    assign hex2     = hex_q[11:8];
    assign hex1     = hex_q[7:4];
    assign hex0     = hex_q[3:0];

endmodule

// File: tb/tb_disp_sched.sv
module tb_disp_sched;

    localparam int F_SRC  = 0;
    localparam int F_HEX  = 1;
    localparam int F_DP   = 2;
    localparam int F_ACK  = 3;
    localparam int F_BUSY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bg_val, cnt_val, msg_val;
    logic        cnt_upd, msg_req;
    logic        msg_ack, msg_busy;
    logic [3:0]  hex3, hex2, hex1, hex0, dp_out;
    logic [1:0]  src;

    disp_sched #(
        .TICK_DIV   (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bg_val   (bg_val),
        .cnt_val  (cnt_val),
        .cnt_upd  (cnt_upd),
        .msg_val  (msg_val),
        .msg_req  (msg_req),
        .msg_ack  (msg_ack),
        .msg_busy (msg_busy),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .dp_out   (dp_out),
        .src      (src)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; after edge n (plus #1) ecount == n.
    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int          e;
        int          fld;
        logic [15:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (edge %0d)", tag, got, want, ecount);
        end
    endtask

    function automatic logic [15:0] obs(input int f);
        case (f)
            F_SRC:   return {14'd0, src};
            F_HEX:   return {hex3, hex2, hex1, hex0};
            F_DP:    return {12'd0, dp_out};
            F_ACK:   return {15'd0, msg_ack};
            default: return {15'd0, msg_busy};
        endcase
    endfunction

    task automatic exp_at(input string tag, input int e, input int f, input logic [15:0] v);
        exp_t x;
        x.e   = e;
        x.fld = f;
        x.val = v;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Outputs are compared mid-cycle, against entries due after this edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].e == ecount) begin
                check(sb[i].tag, obs(sb[i].fld), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_until(input int e);
        while (ecount < e) step();
    endtask

    task automatic txn(input string what, input int k);
        $display("txn %s sampled at edge %0d", what, k);
    endtask

    int k;

    initial begin
        reset   = 1'b1;
        bg_val  = 16'h0123;
        cnt_val = '0;
        msg_val = '0;
        cnt_upd = 1'b0;
        msg_req = 1'b0;

        // ---- reset and background
        step(); step(); step();
        k = ecount + 1;
        txn("reset", k);
        exp_at("rst_src",  k, F_SRC,  16'h0);
        exp_at("rst_hex",  k, F_HEX,  16'h0);
        exp_at("rst_dp",   k, F_DP,   16'h0);
        exp_at("rst_ack",  k, F_ACK,  16'h0);
        exp_at("rst_busy", k, F_BUSY, 16'h0);
        step();
        reset = 1'b0;
        k = ecount + 1;
        txn("release", k);
        exp_at("bg_hex", k + 1, F_HEX, 16'h0123);
        exp_at("bg_dp",  k + 1, F_DP,  16'h0);
        exp_at("bg_src", k + 1, F_SRC, 16'h0);
        step_until(k + 4);

        // ---- counter hold, 12 cycles
        k = ecount + 1;
        txn("cnt 0042", k);
        cnt_val = 16'h0042; cnt_upd = 1'b1;
        exp_at("cnt_src_pre",  k - 1,  F_SRC, 16'h0);
        exp_at("cnt_src_in",   k,      F_SRC, 16'h1);
        exp_at("cnt_hex",      k + 1,  F_HEX, 16'h0042);
        exp_at("cnt_dp",       k + 1,  F_DP,  16'h1);
        exp_at("cnt_src_last", k + 11, F_SRC, 16'h1);
        exp_at("cnt_src_out",  k + 12, F_SRC, 16'h0);
        exp_at("cnt_bg_hex",   k + 14, F_HEX, 16'h0123);
        exp_at("cnt_bg_dp",    k + 14, F_DP,  16'h0);
        step();
        cnt_upd = 1'b0;
        step_until(k + 20);

        // ---- counter hold extended by a second update at cycle 8
        k = ecount + 1;
        txn("cnt extend", k);
        cnt_val = 16'h0042; cnt_upd = 1'b1;
        step();
        cnt_upd = 1'b0;
        step_until(k + 7);
        cnt_val = 16'h0055; cnt_upd = 1'b1;
        exp_at("ext_src_12",  k + 12, F_SRC, 16'h1);
        exp_at("ext_hex",     k + 9,  F_HEX, 16'h0055);
        exp_at("ext_src_19",  k + 19, F_SRC, 16'h1);
        exp_at("ext_src_out", k + 20, F_SRC, 16'h0);
        step();
        cnt_upd = 1'b0;
        step_until(k + 26);

        // ---- message handshake, second request during busy
        k = ecount + 1;
        txn("msg DEAD", k);
        msg_val = 16'hDEAD; msg_req = 1'b1;
        exp_at("msg_ack",      k,      F_ACK,  16'h1);
        exp_at("msg_ack_w",    k + 1,  F_ACK,  16'h0);
        exp_at("msg_busy",     k,      F_BUSY, 16'h1);
        exp_at("msg_src",      k,      F_SRC,  16'h2);
        exp_at("msg_hex",      k + 1,  F_HEX,  16'hDEAD);
        exp_at("msg_dp",       k + 1,  F_DP,   16'h8);
        exp_at("msg_hex_hold", k + 5,  F_HEX,  16'hDEAD);
        exp_at("msg_noack5",   k + 5,  F_ACK,  16'h0);
        exp_at("msg_busy11",   k + 11, F_BUSY, 16'h1);
        exp_at("msg_noack12",  k + 12, F_ACK,  16'h0);
        exp_at("msg_busy12",   k + 12, F_BUSY, 16'h0);
        exp_at("msg2_ack",     k + 13, F_ACK,  16'h1);
        exp_at("msg2_busy",    k + 13, F_BUSY, 16'h1);
        exp_at("msg2_ack_w",   k + 14, F_ACK,  16'h0);
        exp_at("msg2_hex",     k + 14, F_HEX,  16'hBEEF);
        exp_at("msg2_src_out", k + 25, F_SRC,  16'h0);
        step();
        msg_req = 1'b0;
        step_until(k + 3);
        txn("msg BEEF while busy", k + 4);
        msg_val = 16'hBEEF; msg_req = 1'b1;
        step_until(k + 13);
        msg_req = 1'b0;
        step_until(k + 30);

        // ---- pending counter: two updates during MSG, last one wins
        k = ecount + 1;
        txn("msg 1234 + pend", k);
        msg_val = 16'h1234; msg_req = 1'b1;
        exp_at("pend_src_msg", k + 11, F_SRC,  16'h2);
        exp_at("pend_src_cnt", k + 12, F_SRC,  16'h1);
        exp_at("pend_busy",    k + 12, F_BUSY, 16'h0);
        exp_at("pend_hex",     k + 13, F_HEX,  16'h0009);
        exp_at("pend_dp",      k + 13, F_DP,   16'h1);
        exp_at("pend_src_23",  k + 23, F_SRC,  16'h1);
        exp_at("pend_src_out", k + 24, F_SRC,  16'h0);
        step();
        msg_req = 1'b0;
        step_until(k + 1);
        cnt_val = 16'h0007; cnt_upd = 1'b1;
        step();
        cnt_upd = 1'b0;
        step_until(k + 4);
        cnt_val = 16'h0009; cnt_upd = 1'b1;
        step();
        cnt_upd = 1'b0;
        step_until(k + 30);

        // ---- update coinciding with message expiry
        k = ecount + 1;
        txn("msg 4321 + upd at expiry", k);
        msg_val = 16'h4321; msg_req = 1'b1;
        exp_at("coin_src",     k + 12, F_SRC, 16'h1);
        exp_at("coin_hex",     k + 13, F_HEX, 16'h0033);
        exp_at("coin_src_out", k + 24, F_SRC, 16'h0);
        step();
        msg_req = 1'b0;
        step_until(k + 11);
        cnt_val = 16'h0033; cnt_upd = 1'b1;
        step();
        cnt_upd = 1'b0;
        step_until(k + 30);

        // ---- simultaneous msg_req and cnt_upd from BG
        k = ecount + 1;
        txn("simultaneous msg+cnt", k);
        msg_val = 16'h0ABC; msg_req = 1'b1;
        cnt_val = 16'h0066; cnt_upd = 1'b1;
        exp_at("sim_src_msg", k,      F_SRC, 16'h2);
        exp_at("sim_ack",     k,      F_ACK, 16'h1);
        exp_at("sim_hex_msg", k + 1,  F_HEX, 16'h0ABC);
        exp_at("sim_src_cnt", k + 12, F_SRC, 16'h1);
        exp_at("sim_hex_cnt", k + 13, F_HEX, 16'h0066);
        exp_at("sim_src_23",  k + 23, F_SRC, 16'h1);
        exp_at("sim_src_bg",  k + 24, F_SRC, 16'h0);
        step();
        msg_req = 1'b0; cnt_upd = 1'b0;
        step_until(k + 30);

        // ---- reset at cycle 5 of MSG with a counter update pending
        k = ecount + 1;
        txn("msg 0F0F then reset", k);
        msg_val = 16'h0F0F; msg_req = 1'b1;
        exp_at("mrst_busy_pre", k + 4, F_BUSY, 16'h1);
        exp_at("mrst_src",      k + 5, F_SRC,  16'h0);
        exp_at("mrst_hex",      k + 5, F_HEX,  16'h0);
        exp_at("mrst_dp",       k + 5, F_DP,   16'h0);
        exp_at("mrst_ack",      k + 5, F_ACK,  16'h0);
        exp_at("mrst_busy",     k + 5, F_BUSY, 16'h0);
        exp_at("mrst_bg_hex",   k + 8, F_HEX,  16'h0123);
        step();
        msg_req = 1'b0;
        step_until(k + 2);
        cnt_val = 16'h0077; cnt_upd = 1'b1;
        step();
        cnt_upd = 1'b0;
        step_until(k + 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step_until(k + 9);

        // A cleared pend means the next message expires straight to BG.
        k = ecount + 1;
        txn("msg after reset", k);
        msg_val = 16'h5A5A; msg_req = 1'b1;
        exp_at("post_src_msg", k + 11, F_SRC, 16'h2);
        exp_at("post_src_bg",  k + 12, F_SRC, 16'h0);
        exp_at("post_hex_bg",  k + 14, F_HEX, 16'h0123);
        step();
        msg_req = 1'b0;
        step_until(k + 20);

        check("sb_drain", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
